instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
IF stage of the 5-stage pipeline. Owns the PC, drives the byte address into the byte-addressed, big-endian instruction memory, and captures the returned 32-bit word plus PC+4 into the IF/ID pipeline register. Takes stall from the hazard unit and redirect (jump/branch) from ID, and stops fetching cleanly at the end of the loaded program image.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_BYTES, 24, instruction memory size in bytes; last valid fetch address is MEM_BYTES-4
NOP_WORD, 32'h0000_0000, word inserted into IF/ID for bubbles and flushes

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall_if  input  1  hazard unit: hold PC and IF/ID
redirect_valid  input  1  ID-stage jump/branch taken this cycle
redirect_pc  input  32  target byte address for the redirect
imem_addr  output  32  byte address to instruction memory; equals PC
imem_data  input  32  instruction word returned combinationally, {Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]}
if_id_instr  output  32  IF/ID instruction register
if_id_pc_plus4  output  32  IF/ID PC+4 register
if_id_valid  output  1  IF/ID holds a real instruction
fetch_done  output  1  PC is past the last valid word; no further fetches

Behaviour:
- Reset (synchronous, also mid-operation): PC<=RESET_PC; if_id_instr<=NOP_WORD; if_id_pc_plus4<=0; if_id_valid<=0; fetch_done<=0. Reset has priority over all other inputs.
- imem_addr = PC, combinational. The instruction for a PC is in IF/ID on the following edge, giving 1-cycle IF latency.
- in_range = (PC <= MEM_BYTES-4). Use a 33-bit compare so PC values near 2^32 are out of range and do not wrap.
- Priority per edge, after reset:
  1) redirect_valid: PC<=redirect_pc. IF/ID loads a bubble (NOP_WORD, valid=0, pc_plus4=0), which flushes the wrong-path word. Redirect wins over a simultaneous stall_if.
  2) stall_if: PC and all IF/ID registers hold.
  3) !in_range: PC holds, IF/ID loads a bubble, fetch_done<=1.
  4) otherwise: IF/ID <= {imem_data, PC+4, valid=1}, then next PC (see Optional Feature; default PC+4, modulo 2^32).
- fetch_done is cleared by reset or by a redirect into range. A redirect to an out-of-range target sets fetch_done on the following edge.
- Misaligned PC (PC[1:0]!=0) is fetched as given; alignment is not checked here.
- No combinational path from stall_if or redirect_* to imem_addr.

Optional Feature:
EARLY_JUMP_EN
- Defined: the IF stage predecodes imem_data. If opcode imem_data[31:26]==6'b000010 (J) and the fetch is proceeding under case 4, next PC = {6'b0, imem_data[25:0]}. The target is the raw byte address, unshifted, matching the assembler's J encoding. The J word itself still enters IF/ID with valid=1, so the jump costs no bubble. ID must not re-redirect on J; any redirect that does arrive still has priority.
- Undefined: next PC is always PC+4. J is resolved in ID through redirect_valid, which costs one flushed slot.

Decomposition:
- Shared package cpu_pkg: OPC_J = 6'b000010, NOP_WORD default, field slice constants (OPC_MSB=31, OPC_LSB=26, JTGT_MSB=25), and the typedef for the IF/ID bundle {instr, pc_plus4, valid}.
- One sub-module is natural: if_id_reg, the IF/ID pipeline register with hold (stall) and bubble (flush) controls, reused in the ID/EX style. PC and next-PC logic stay in instruction_fetch.

Test Plan:
- Reset, memory loaded with program A161000C, ED021800, C8611000, 08000014, ECC63000, EC652000 -> imem_addr=0, if_id_valid=0. After 1 edge: if_id_instr=A161000C, if_id_pc_plus4=4, imem_addr=4.
- stall_if=1 for 2 cycles while PC=8 -> PC stays 8, if_id_instr stays ED021800 for both cycles. After release: if_id_instr=C8611000, if_id_pc_plus4=12.
- Without EARLY_JUMP_EN: fetch J at PC=12, then redirect_valid=1 with redirect_pc=0x14 while PC=16 -> next edge: PC=0x14, if_id_valid=0, if_id_instr=0. Following edge: if_id_instr=EC652000, if_id_pc_plus4=0x18.
- With EARLY_JUMP_EN: at PC=12 -> IF/ID gets 08000014 (valid=1), next PC=0x14. Next edge: if_id_instr=EC652000, with no bubble and ECC63000 never fetched.
- Run to PC=24 with MEM_BYTES=24 -> fetch_done=1, PC holds 24, bubbles every cycle. Then redirect to 0 -> fetch_done=0 and A161000C is fetched again.
- Assert reset for 1 cycle mid-run at PC=16 together with stall_if=1 and redirect_valid=1 -> PC=0, if_id_valid=0, fetch_done=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: opcode fields,
// bubble word and the IF/ID bundle.
package cpu_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int JTGT_MSB = 25;

  localparam logic [5:0]  OPC_J        = 6'b000010;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic if_id_t bubble_of(
    input logic [31:0] nop
  );
    if_id_t b;
    b.instr    = nop;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id.sv
// IF/ID pipeline register with hold and
// bubble controls; bubble beats hold.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  // load, hold or squash the stage contents
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= bubble_of(NOP_WORD);
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, next-PC select, IF/ID capture.
// EARLY_JUMP_EN: resolve J opcodes in IF.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 24,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_done
);

  localparam logic [32:0] LAST_ADDR =
    33'(MEM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        done_next;
  logic        in_range;
  logic        take_j;
  logic [31:0] j_target;

  logic sel_redir;
  logic sel_hold;
  logic sel_end;
  logic sel_run;

  if_id_t if_id_d;
  if_id_t if_id_q;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign in_range  = {1'b0, pc} <= LAST_ADDR;
  assign j_target  =
    {6'b0, imem_data[JTGT_MSB:0]};

`ifdef EARLY_JUMP_EN
  assign take_j =
    imem_data[OPC_MSB:OPC_LSB] == OPC_J;
`else
  assign take_j = 1'b0;
`endif

  assign sel_redir = redirect_valid;
  assign sel_hold  = !redirect_valid
                   && stall_if;
  assign sel_end   = !redirect_valid
                   && !stall_if
                   && !in_range;
  assign sel_run   = !redirect_valid
                   && !stall_if
                   && in_range;

  // next PC and end-of-image flag
  always_comb begin
    pc_next   = pc;
    done_next = fetch_done;
    unique case (1'b1)
      sel_redir: begin
        pc_next   = redirect_pc;
        done_next = 1'b0;
      end
      sel_hold: begin
        pc_next = pc;
      end
      sel_end: begin
        done_next = 1'b1;
      end
      sel_run: begin
        pc_next = take_j ? j_target
                         : pc_plus4;
      end
      default: begin
        pc_next = pc;
      end
    endcase
  end

  // PC and fetch_done state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      fetch_done <= 1'b0;
    end else begin
      pc         <= pc_next;
      fetch_done <= done_next;
    end
  end

  // word fetched this cycle
  always_comb begin
    if_id_d.instr    = imem_data;
    if_id_d.pc_plus4 = pc_plus4;
    if_id_d.valid    = 1'b1;
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .hold  (sel_hold),
    .bubble(sel_redir || sel_end),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;

endmodule
